// File: rtl/banco_registradores.sv
// Register file: R0 hardwired to zero, R1..R(N-1) written on the rising clock edge,
// and two independent read ports with combinational, unbypassed reads.
module banco_registradores #(
    parameter  int LARGURA_DADO = 8,
    parameter  int NUM_REGS     = 8,
    localparam int LARGURA_END  = $clog2(NUM_REGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA_END-1:0]  reg_leitura1,
    input  logic [LARGURA_END-1:0]  reg_leitura2,
    input  logic [LARGURA_END-1:0]  reg_escrita,
    input  logic [LARGURA_DADO-1:0] dado_escrita,
    input  logic                    escreve_reg,
    output logic [LARGURA_DADO-1:0] dado_lido1,
    output logic [LARGURA_DADO-1:0] dado_lido2
);

    // R0 has no storage; its address simply decodes to zero on the read side.
    logic [LARGURA_DADO-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (escreve_reg) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (reg_escrita == LARGURA_END'(i)) begin
                    regs[i] <= dado_escrita;
                end
            end
        end
    end

    // Reads look only at stored state, so the write-side inputs never reach the outputs
    // combinationally and the ALU loop in the single-cycle datapath stays broken.
    always_comb begin
        dado_lido1 = '0;
        dado_lido2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (reg_leitura1 == LARGURA_END'(i)) begin
                dado_lido1 = regs[i];
            end
            if (reg_leitura2 == LARGURA_END'(i)) begin
                dado_lido2 = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores: stimulus queues expected read data,
// an independent monitor samples both read ports and compares.
module tb_banco_registradores;

    logic       clock;
    logic       reset;
    logic [2:0] reg_leitura1;
    logic [2:0] reg_leitura2;
    logic [2:0] reg_escrita;
    logic [7:0] dado_escrita;
    logic       escreve_reg;
    logic [7:0] dado_lido1;
    logic [7:0] dado_lido2;

    banco_registradores #(.LARGURA_DADO(8), .NUM_REGS(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .reg_leitura1 (reg_leitura1),
        .reg_leitura2 (reg_leitura2),
        .reg_escrita  (reg_escrita),
        .dado_escrita (dado_escrita),
        .escreve_reg  (escreve_reg),
        .dado_lido1   (dado_lido1),
        .dado_lido2   (dado_lido2)
    );

    typedef struct {
        string      nome;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
    } esperado_t;

    esperado_t sb[$];
    event      ev_chk;
    int        n_tests = 0;
    int        n_fail  = 0;

    // Long period so that a full sweep of checks fits inside one half-cycle.
    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion before it");
        $fatal(1);
    end

    // Monitor: pops one expectation per strobe and compares both ports.
    initial begin
        esperado_t e;
        forever begin
            @(ev_chk);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: strobe with empty queue, required one entry");
            end else begin
                e = sb.pop_front();
                n_tests++;
                if (dado_lido1 !== e.e1 || dado_lido2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s: addr1=%0d addr2=%0d got %h/%h, required %h/%h",
                             e.nome, e.a1, e.a2, dado_lido1, dado_lido2, e.e1, e.e2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string nome, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [7:0] e1, input logic [7:0] e2);
        esperado_t e;
        reg_leitura1 = a1;
        reg_leitura2 = a2;
        #1;
        e.nome = nome; e.a1 = a1; e.a2 = a2; e.e1 = e1; e.e2 = e2;
        sb.push_back(e);
        -> ev_chk;
        #1;
    endtask

    task automatic escreve(input logic [2:0] r, input logic [7:0] d);
        reg_escrita  = r;
        dado_escrita = d;
        escreve_reg  = 1'b1;
        tick();
        escreve_reg  = 1'b0;
    endtask

    logic [7:0] val [0:7];

    initial begin
        reset        = 1'b0;
        reg_leitura1 = '0;
        reg_leitura2 = '0;
        escreve_reg  = 1'b1;
        reg_escrita  = 3'd3;
        dado_escrita = 8'hAA;
        @(negedge clock);

        // Reset held for two edges with a simultaneous write to R3.
        tick();
        tick();
        reset       = 1'b1;
        escreve_reg = 1'b0;
        for (int i = 0; i < 8; i++) chk("reset_sweep", 3'(i), 3'(7 - i), 8'h00, 8'h00);

        // Write 0x11*i into Ri; a pending write must not show before its edge.
        for (int i = 1; i < 8; i++) begin
            reg_escrita  = 3'(i);
            dado_escrita = 8'(8'h11 * i);
            escreve_reg  = 1'b1;
            if (i == 1 || i == 7) chk("pre_edge_write", 3'(i), 3'(i), 8'h00, 8'h00);
            tick();
        end
        escreve_reg = 1'b0;
        val[0] = 8'h00; val[1] = 8'h11; val[2] = 8'h22; val[3] = 8'h33;
        val[4] = 8'h44; val[5] = 8'h55; val[6] = 8'h66; val[7] = 8'h77;
        for (int i = 0; i < 8; i++) chk("write_sweep", 3'(i), 3'(7 - i), val[i], val[7 - i]);

        // Writes to R0 are dropped and touch nothing else.
        escreve(3'd0, 8'hFF);
        chk("r0_write", 3'd0, 3'd0, 8'h00, 8'h00);
        for (int i = 1; i < 8; i++) chk("r0_others", 3'(i), 3'(i), val[i], val[i]);

        // No bypass: old value before the edge, new value after it.
        escreve(3'd2, 8'h05);
        reg_escrita  = 3'd2;
        dado_escrita = 8'h3C;
        escreve_reg  = 1'b1;
        chk("bypass_before", 3'd2, 3'd2, 8'h05, 8'h05);
        tick();
        escreve_reg = 1'b0;
        chk("bypass_after", 3'd2, 3'd1, 8'h3C, 8'h11);

        // Disabled write for three edges, then undefined data with write blocked.
        reg_escrita  = 3'd4;
        dado_escrita = 8'h77;
        escreve_reg  = 1'b0;
        repeat (3) tick();
        chk("enable_off", 3'd4, 3'd4, 8'h44, 8'h44);
        dado_escrita = 8'hxx;
        tick();
        chk("x_data_disabled", 3'd4, 3'd3, 8'h44, 8'h33);
        reg_escrita = 3'd0;
        escreve_reg = 1'b1;
        tick();
        escreve_reg = 1'b0;
        chk("x_data_r0", 3'd6, 3'd7, 8'h66, 8'h77);

        // Mid-run reset takes effect only at the next edge.
        escreve(3'd5, 8'h9E);
        reset = 1'b0;
        chk("midreset_before", 3'd3, 3'd5, 8'h33, 8'h9E);
        tick();
        chk("midreset_after", 3'd3, 3'd5, 8'h00, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) chk("midreset_sweep", 3'(i), 3'(i), 8'h00, 8'h00);

        begin
            int espera;
            espera = 0;
            while (sb.size() != 0 && espera < 100) begin
                #1;
                espera++;
            end
            if (sb.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d entries left in queue, required 0", sb.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/banco_registradores.md
BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter: LARGURA_DADO, default 8, data width of each register; fixed at 8 in this processor.
REQ-002 Parameter: NUM_REGS, default 8, number of registers; register address width is 3.
REQ-003 Port: clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port: reset, input, 1, synchronous active-low reset, sampled only on the rising edge of clock.
REQ-005 Port: reg_leitura1, input, 3, address for read port 1 (ALU operand A).
REQ-006 Port: reg_leitura2, input, 3, address for read port 2 (operand B; feeds the 8-bit ALU-source mux).
REQ-007 Port: reg_escrita, input, 3, write address.
REQ-008 Port: dado_escrita, input, 8, write data (ALU result or memory data, from the write-back mux).
REQ-009 Port: escreve_reg, input, 1, write enable, active high.
REQ-010 Port: dado_lido1, output, 8, read data for port 1.
REQ-011 Port: dado_lido2, output, 8, read data for port 2.

Function
REQ-012 Storage SHALL be NUM_REGS registers of LARGURA_DADO bits (R0..R7).
REQ-013 R0 SHALL always read as 8'h00, and writes to R0 SHALL be discarded without error.
REQ-014 Reads SHALL be combinational, with zero latency: dado_lidoN = R[reg_leituraN] in the same cycle, and a read SHALL update when the address or stored value changes.
REQ-015 A write SHALL occur on the rising edge when reset=1, escreve_reg=1 and reg_escrita!=0, loading dado_escrita into R[reg_escrita].
REQ-016 When escreve_reg=0, no register SHALL change.
REQ-017 There SHALL be no write-to-read bypass. If a read address equals the write address in the same cycle, the read SHALL return the old value until the edge and the new value after it. This is required to avoid a combinational loop through the ALU in the single-cycle datapath.
REQ-018 Both read ports SHALL be independent. Both may address the same register, and both SHALL return identical data.
REQ-019 Exactly one register, at most, SHALL change per cycle. All other registers SHALL hold their values.
REQ-020 X or undefined data on dado_escrita SHALL NOT corrupt any register when escreve_reg=0 or reg_escrita=0.
REQ-021 The block SHALL contain no combinational path from dado_escrita, escreve_reg or reg_escrita to dado_lido1 or dado_lido2.

Reset
REQ-022 On a rising edge with reset=0, R1..R7 SHALL clear to 8'h00. This reset SHALL override any simultaneous write.
REQ-023 Following that edge, dado_lido1 and dado_lido2 SHALL read 8'h00 for every address.
REQ-024 Register contents before the first reset edge are undefined, and no requirement applies to them.
REQ-025 Asserting reset during normal operation SHALL take effect only at the next rising edge. Until then, reads SHALL return the pre-reset contents.

Verification
REQ-026 Reset scenario: reset=0 for 2 edges while escreve_reg=1, reg_escrita=3, dado_escrita=8'hAA; then reset=1. Required response: reading addresses 0..7 returns 8'h00 on both ports, so the write was suppressed.
REQ-027 Write/read scenario: write 8'h11*i to Ri for i=1..7 on consecutive edges, then sweep both read ports across all addresses. Required response: Ri reads 8'h11*i and R0 reads 8'h00.
REQ-028 R0 scenario: escreve_reg=1, reg_escrita=0, dado_escrita=8'hFF for one edge. Required response: dado_lido1 with reg_leitura1=0 stays 8'h00, and R1..R7 are unchanged.
REQ-029 No-bypass scenario: start with R2=8'h05 and reg_leitura1=2. Set reg_escrita=2, dado_escrita=8'h3C, escreve_reg=1. Required response: dado_lido1=8'h05 before the edge and 8'h3C immediately after it.
REQ-030 Enable scenario: set escreve_reg=0 with reg_escrita=4 and dado_escrita=8'h77 for 3 edges. Required response: R4 keeps its prior value, and dual reads of R4 on both ports match.
REQ-031 Mid-run reset scenario: with R5=8'h9E, drive reset=0 for 1 edge. Required response: dado_lido2 with reg_leitura2=5 reads 8'h9E before the edge and 8'h00 after it.
